// File: rtl/ahb_slv_fifo_push.sv
// AHB-Lite slave front-end for the bridge source side: packs each transfer into a
// command word for the async command FIFO and stalls reads until the response returns.
module ahb_slv_fifo_push #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int CMD_W = 1 + 3 + ADDR_W + DATA_W
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic              w_inc,
  output logic [CMD_W-1:0]  w_data,
  input  logic              full,
  input  logic [DATA_W:0]   rsp_data,
  input  logic              rsp_empty,
  output logic              rsp_inc
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_RCMD  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RDONE = 3'd4,
    ST_ERR1  = 3'd5,
    ST_ERR2  = 3'd6
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  state_t              cap_state_s;
  logic                write_r;
  logic [2:0]          size_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   hrdata_r;
  logic                active_trans_s;
  logic                cap_req_s;
  logic                cap_en_s;
  logic                hreadyout_s;
  logic                hresp_s;
  logic                w_inc_s;
  logic                rsp_inc_s;
  logic [CMD_W-1:0]    w_data_s;

  assign active_trans_s = (HTRANS inside {2'b10, 2'b11});
  assign cap_req_s      = HSEL & active_trans_s & HREADY;
  assign cap_state_s    = HWRITE ? ST_WDATA : ST_RCMD;

  // Next-state, handshake outputs and capture enable, all decoded from the current state.
  always_comb begin
    state_nxt_s = state_r;
    hreadyout_s = 1'b1;
    hresp_s     = 1'b0;
    w_inc_s     = 1'b0;
    rsp_inc_s   = 1'b0;
    w_data_s    = {CMD_W{1'b0}};
    cap_en_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_RDONE: begin
        cap_en_s = cap_req_s;
        if (cap_req_s) begin
          state_nxt_s = cap_state_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WDATA: begin
        hreadyout_s = ~full;
        w_inc_s     = ~full;
        w_data_s    = {write_r, size_r, addr_r, HWDATA};
        cap_en_s    = cap_req_s & ~full;
        if (full) begin
          state_nxt_s = ST_WDATA;
        end else if (cap_req_s) begin
          state_nxt_s = cap_state_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RCMD: begin
        hreadyout_s = 1'b0;
        w_inc_s     = ~full;
        w_data_s    = {write_r, size_r, addr_r, {DATA_W{1'b0}}};
        if (full) begin
          state_nxt_s = ST_RCMD;
        end else begin
          state_nxt_s = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        hreadyout_s = 1'b0;
        rsp_inc_s   = ~rsp_empty;
        if (rsp_empty) begin
          state_nxt_s = ST_RWAIT;
        end else if (rsp_data[DATA_W]) begin
          state_nxt_s = ST_ERR1;
        end else begin
          state_nxt_s = ST_RDONE;
        end
      end
      ST_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = 1'b1;
        state_nxt_s = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_s  = 1'b1;
        cap_en_s = cap_req_s;
        if (cap_req_s) begin
          state_nxt_s = cap_state_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and address-phase capture.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_r <= ST_IDLE;
      write_r <= 1'b0;
      size_r  <= 3'b000;
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (cap_en_s) begin
        write_r <= HWRITE;
        size_r  <= HSIZE;
        addr_r  <= HADDR;
      end
    end
  end

  // Read data is latched on the response pop so it is stable through RDONE/ERR.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      hrdata_r <= {DATA_W{1'b0}};
    end else if (rsp_inc_s) begin
      hrdata_r <= rsp_data[DATA_W-1:0];
    end
  end

  assign HREADYOUT = hreadyout_s;
  assign HRESP     = hresp_s;
  assign HRDATA    = hrdata_r;
  assign w_inc     = w_inc_s;
  assign w_data    = w_data_s;
  assign rsp_inc   = rsp_inc_s;

endmodule

// File: tb/tb_ahb_slv_fifo_push.sv
// Directed bench for ahb_slv_fifo_push: writes, full stalls, reads, error reads,
// back-to-back pipelining and reset while a read is outstanding.
module tb_ahb_slv_fifo_push;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 1 + 3 + ADDR_W + DATA_W;

  logic              w_clk;
  logic              w_rst;
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  logic              w_inc;
  logic [CMD_W-1:0]  w_data;
  logic              full;
  logic [DATA_W:0]   rsp_data;
  logic              rsp_empty;
  logic              rsp_inc;

  int tests_run = 0;
  int tests_failed = 0;
  int push_cnt = 0;
  int base;
  logic [CMD_W-1:0] pushed_q[$];

  assign hready = hreadyout;

  ahb_slv_fifo_push #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .w_inc(w_inc),
    .w_data(w_data), .full(full), .rsp_data(rsp_data), .rsp_empty(rsp_empty),
    .rsp_inc(rsp_inc)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Record every word the FIFO would accept.
  always @(negedge w_clk) begin
    if (w_inc === 1'b1 && full === 1'b0) begin
      push_cnt = push_cnt + 1;
      pushed_q.push_back(w_data);
    end
  end

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = 3'b010;
    haddr  = a;
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  initial begin
    w_rst = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b000; hwdata = 32'h0; full = 1'b0; rsp_data = 33'h0; rsp_empty = 1'b1;
    repeat (2) @(posedge w_clk);
    #1;
    check_eq("rst_hreadyout", hreadyout, 1'b1);
    check_eq("rst_hresp", hresp, 1'b0);
    check_eq("rst_hrdata", hrdata, 32'h0);
    check_eq("rst_w_inc", w_inc, 1'b0);
    check_eq("rst_rsp_inc", rsp_inc, 1'b0);
    w_rst = 1'b0;

    // single write
    base = push_cnt;
    tick(); addr_phase(1'b1, 32'h1000_0040); #1;
    check_eq("wr_t0_ready", hreadyout, 1'b1);
    check_eq("wr_t0_winc", w_inc, 1'b0);
    tick(); idle_bus(); hwdata = 32'hDEAD_BEEF; #1;
    check_eq("wr_t1_winc", w_inc, 1'b1);
    check_eq("wr_t1_wdata", w_data, {1'b1, 3'b010, 32'h1000_0040, 32'hDEAD_BEEF});
    check_eq("wr_t1_ready", hreadyout, 1'b1);
    tick(); #1;
    check_eq("wr_t2_winc", w_inc, 1'b0);
    check_eq("wr_t2_ready", hreadyout, 1'b1);
    check_eq("wr_pushes", push_cnt - base, 1);

    // write stalled by full for three cycles
    base = push_cnt;
    tick(); addr_phase(1'b1, 32'h1000_0040); full = 1'b1; #1;
    check_eq("full_t0_ready", hreadyout, 1'b1);
    tick(); idle_bus(); hwdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("full_stall_ready", hreadyout, 1'b0);
      check_eq("full_stall_winc", w_inc, 1'b0);
      tick();
    end
    full = 1'b0; #1;
    check_eq("full_rel_winc", w_inc, 1'b1);
    check_eq("full_rel_ready", hreadyout, 1'b1);
    check_eq("full_rel_wdata", w_data, {1'b1, 3'b010, 32'h1000_0040, 32'hDEAD_BEEF});
    tick(); #1;
    check_eq("full_pushes", push_cnt - base, 1);
    check_eq("full_done_ready", hreadyout, 1'b1);

    // read with response available from T2
    tick(); addr_phase(1'b0, 32'h2000_0000); #1;
    tick(); idle_bus(); #1;
    check_eq("rd_t1_ready", hreadyout, 1'b0);
    check_eq("rd_t1_winc", w_inc, 1'b1);
    check_eq("rd_t1_wdata", w_data, {1'b0, 3'b010, 32'h2000_0000, 32'h0});
    check_eq("rd_t1_rspinc", rsp_inc, 1'b0);
    tick(); rsp_data = 33'h0_1234_5678; rsp_empty = 1'b0; #1;
    check_eq("rd_t2_rspinc", rsp_inc, 1'b1);
    check_eq("rd_t2_ready", hreadyout, 1'b0);
    check_eq("rd_t2_winc", w_inc, 1'b0);
    tick(); rsp_empty = 1'b1; #1;
    check_eq("rd_t3_hrdata", hrdata, 32'h1234_5678);
    check_eq("rd_t3_ready", hreadyout, 1'b1);
    check_eq("rd_t3_hresp", hresp, 1'b0);

    // read error, with one extra RWAIT cycle
    tick(); addr_phase(1'b0, 32'h2000_0010); #1;
    tick(); idle_bus(); #1;
    check_eq("err_rcmd_winc", w_inc, 1'b1);
    tick(); #1;
    check_eq("err_wait_rspinc", rsp_inc, 1'b0);
    check_eq("err_wait_ready", hreadyout, 1'b0);
    tick(); rsp_data = 33'h1_0BAD_0BAD; rsp_empty = 1'b0; #1;
    check_eq("err_pop_rspinc", rsp_inc, 1'b1);
    tick(); rsp_empty = 1'b1; #1;
    check_eq("err1_ready", hreadyout, 1'b0);
    check_eq("err1_hresp", hresp, 1'b1);
    tick(); #1;
    check_eq("err2_ready", hreadyout, 1'b1);
    check_eq("err2_hresp", hresp, 1'b1);
    tick(); #1;
    check_eq("err_idle_ready", hreadyout, 1'b1);
    check_eq("err_idle_hresp", hresp, 1'b0);

    // back-to-back write, write, read
    base = push_cnt;
    tick(); addr_phase(1'b1, 32'h3000_0000); #1;
    tick(); addr_phase(1'b1, 32'h3000_0004); hwdata = 32'h1111_1111; #1;
    check_eq("b2b_w1_winc", w_inc, 1'b1);
    check_eq("b2b_w1_ready", hreadyout, 1'b1);
    tick(); addr_phase(1'b0, 32'h3000_0008); hwdata = 32'h2222_2222; #1;
    check_eq("b2b_w2_winc", w_inc, 1'b1);
    check_eq("b2b_w2_ready", hreadyout, 1'b1);
    tick(); idle_bus(); #1;
    check_eq("b2b_rcmd_ready", hreadyout, 1'b0);
    check_eq("b2b_rcmd_winc", w_inc, 1'b1);
    tick(); rsp_data = 33'h0_ABCD_0123; rsp_empty = 1'b0; #1;
    check_eq("b2b_pop", rsp_inc, 1'b1);
    tick(); rsp_empty = 1'b1; #1;
    check_eq("b2b_hrdata", hrdata, 32'hABCD_0123);
    check_eq("b2b_done_ready", hreadyout, 1'b1);
    check_eq("b2b_pushes", push_cnt - base, 3);
    if (push_cnt - base == 3) begin
      check_eq("b2b_word0", pushed_q[base],     {1'b1, 3'b010, 32'h3000_0000, 32'h1111_1111});
      check_eq("b2b_word1", pushed_q[base + 1], {1'b1, 3'b010, 32'h3000_0004, 32'h2222_2222});
      check_eq("b2b_word2", pushed_q[base + 2], {1'b0, 3'b010, 32'h3000_0008, 32'h0});
    end

    // reset while waiting for a response
    tick(); addr_phase(1'b0, 32'h4000_0000); #1;
    tick(); idle_bus(); #1;
    tick(); #1;
    check_eq("rst_rwait_ready", hreadyout, 1'b0);
    w_rst = 1'b1; rsp_empty = 1'b0; #1;
    check_eq("rst_mid_ready", hreadyout, 1'b1);
    check_eq("rst_mid_rspinc", rsp_inc, 1'b0);
    check_eq("rst_mid_winc", w_inc, 1'b0);
    tick(); w_rst = 1'b0; rsp_empty = 1'b1;
    base = push_cnt;
    tick(); addr_phase(1'b1, 32'h5000_0000); #1;
    tick(); idle_bus(); hwdata = 32'h5555_AAAA; #1;
    check_eq("post_rst_winc", w_inc, 1'b1);
    check_eq("post_rst_wdata", w_data, {1'b1, 3'b010, 32'h5000_0000, 32'h5555_AAAA});
    tick(); #1;
    check_eq("post_rst_pushes", push_cnt - base, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_slv_fifo_push.md
# ahb_slv_fifo_push

AHB-Lite slave front-end of the AHB2AHB bridge's source side. It captures AHB transfers and packs each into a command word. The command word is pushed into the write port of the asynchronous command FIFO, and the block drives that FIFO's `w_inc` and honours its `full` flag. Writes are posted. Reads stall the bus until the matching response word is popped from the return (response) FIFO.

## Interface
Parameters:
- `ADDR_W`, 32, AHB address width
- `DATA_W`, 32, AHB data width
- `CMD_W`, local, fixed to 1+3+ADDR_W+DATA_W; command word `{write, size[2:0], addr, wdata}`

Ports:
- `w_clk`  in  1  write-domain clock (AHB source clock)
- `w_rst`  in  1  asynchronous, active-high reset
- `HSEL`  in  1  slave select
- `HADDR`  in  ADDR_W  address
- `HTRANS`  in  2  transfer type; bit 1 set = NONSEQ/SEQ
- `HWRITE`  in  1  1 = write
- `HSIZE`  in  3  transfer size
- `HWDATA`  in  DATA_W  write data, valid in the data phase
- `HREADY`  in  1  bus-wide ready
- `HREADYOUT`  out  1  slave ready
- `HRESP`  out  1  0 = OKAY, 1 = ERROR
- `HRDATA`  out  DATA_W  read data, registered
- `w_inc`  out  1  command FIFO push strobe
- `w_data`  out  CMD_W  command word, valid while `w_inc` = 1
- `full`  in  1  command FIFO full
- `rsp_data`  in  DATA_W+1  response word `{err, rdata}`
- `rsp_empty`  in  1  response FIFO empty
- `rsp_inc`  out  1  response FIFO pop strobe

## Operation
- **Reset values:** state IDLE, `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0, `w_inc`=0, `rsp_inc`=0, captured regs 0.
- **Capture:** when `HSEL & HTRANS[1] & HREADY` at a rising edge, register `HWRITE`, `HSIZE`, `HADDR`.
  - Next state is WDATA for a write, RCMD for a read.
  - IDLE/BUSY or unselected transfers give a zero-wait OKAY, push nothing, and leave the state at IDLE.
- **FSM states:**
  - **IDLE:** `HREADYOUT`=1; capture allowed.
  - **WDATA:** `w_inc` = !`full`, `w_data` = {1, size_q, addr_q, `HWDATA`}, `HREADYOUT` = !`full`.
    - Stays in WDATA while `full`=1.
    - When not full, capture is allowed in the same cycle, giving a pipelined back-to-back transfer.
  - **RCMD:** `HREADYOUT`=0, `w_inc` = !`full`, `w_data` = {0, size_q, addr_q, 0}. Moves to RWAIT on a push.
  - **RWAIT:** `HREADYOUT`=0, `rsp_inc` = !`rsp_empty`.
    - On a pop, register `HRDATA` <= `rsp_data[DATA_W-1:0]`.
    - Next state is ERR1 if `rsp_data[DATA_W]`=1, else RDONE.
  - **RDONE:** `HREADYOUT`=1, `HRESP`=0; capture allowed; otherwise returns to IDLE.
  - **ERR1:** `HREADYOUT`=0, `HRESP`=1, then ERR2.
  - **ERR2:** `HREADYOUT`=1, `HRESP`=1; capture allowed; otherwise returns to IDLE.
- **Strobes:** `w_inc` and `rsp_inc` are combinational from state and flags. The block never asserts `w_inc` while `full`=1, and never asserts `rsp_inc` while `rsp_empty`=1.
- **Outstanding reads:** at most one. Writes are posted and always answer OKAY.
- **Reset mid-operation:** returns immediately to IDLE. An in-flight command that was not yet pushed is dropped. A response that was not yet popped stays in the response FIFO; flushing it is the bridge reset's responsibility.

## Timing
- **Write:** address phase at cycle T0; data phase T1 pushes at the T1/T2 edge. Zero wait states when `full`=0; one extra wait state per cycle of `full`=1.
- **Read:** address phase T0, RCMD T1 (push), RWAIT T2 (pop if a response is available), RDONE T3.
  - Minimum of 2 wait states; `HRDATA` is valid in the T3 data phase.
  - RWAIT extends one cycle per cycle of `rsp_empty`=1.
- **Error:** exactly two data-phase cycles, `HREADYOUT` 0 then 1, with `HRESP`=1 in both.
- **Push order:** commands enter the FIFO in AHB order. One push per cycle maximum.

## Test plan
- **Single write:** write addr 0x1000_0040, data 0xDEAD_BEEF, HSIZE=2, `full`=0 -> `w_inc`=1 for one cycle in T1, `w_data`={1,3'b010,0x1000_0040,0xDEAD_BEEF}, `HREADYOUT`=1 throughout.
- **Full stall:** same write with `full`=1 for 3 cycles -> `HREADYOUT`=0 and `w_inc`=0 for 3 cycles, then one push; exactly 1 word is written.
- **Read:** read 0x2000_0000; response {0, 0x1234_5678} present from T2 -> `rsp_inc`=1 at T2, `HRDATA`=0x1234_5678 with `HREADYOUT`=1 at T3, `HRESP`=0.
- **Read error:** response {1, x} -> `HREADYOUT`=0/`HRESP`=1, then `HREADYOUT`=1/`HRESP`=1, then IDLE with `HRESP`=0.
- **Back-to-back:** write, write, read with no idle cycles -> 3 pushes in order (write, write, read), the second write has zero wait states, and the read completes after its response.
- **Reset in RWAIT:** assert `w_rst` while waiting -> `HREADYOUT`=1, `rsp_inc`=0, state IDLE; the next write after reset release pushes normally.
